cache_refill_ctrl: RTL and testbench

Miss-handling and write-through controller sitting between the CPU load/store port, the 4-way data cache, and main memory. It serves read hits directly from the cache. On a read miss it fetches the word from memory, writes it into the cache through the cache's write port, then returns it. Stores are written through to memory and allocated into the cache. It also provides a memory-timeout error path and hit/miss statistics counters.

---
 rtl/cache_refill_ctrl.sv | 166 ++++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_ctrl.sv
// Miss-handling and write-through controller between the CPU port, the data cache and memory.
// Read hits complete combinationally; misses and stores go through memory with a wait timeout.
module cache_refill_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  output logic [31:0] cache_addr,
  output logic [31:0] cache_wdata,
  output logic        cache_we,
  input  logic [31:0] cache_rdata,
  input  logic        cache_hit,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_MEM_RD, S_MEM_WR, S_FILL, S_WR_DONE, S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      line_q, line_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [31:0]      hit_cnt_q, hit_cnt_d;
  logic [31:0]      miss_cnt_q, miss_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      line_q     <= '0;
      wait_q     <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      line_q     <= line_d;
      wait_q     <= wait_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    line_d     = line_q;
    wait_d     = wait_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          if (cpu_we) begin
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
            wait_d  = '0;
            state_d = S_MEM_WR;
          end else if (cache_hit) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
          end else begin
            addr_d     = cpu_addr;
            miss_cnt_d = miss_cnt_q + 32'd1;
            wait_d     = '0;
            state_d    = S_MEM_RD;
          end
        end
      end
      // An ack arriving on the limit cycle takes priority over the timeout.
      S_MEM_RD: begin
        if (mem_ack) begin
          line_d  = mem_rdata;
          state_d = S_FILL;
        end else if (wait_q == WAIT_LIMIT) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_MEM_WR: begin
        if (mem_ack) begin
          state_d = S_WR_DONE;
        end else if (wait_q == WAIT_LIMIT) begin
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_ready   = 1'b0;
    cpu_err     = 1'b0;
    cpu_rdata   = '0;
    cache_addr  = addr_q;
    cache_wdata = wdata_q;
    cache_we    = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = addr_q;
    mem_wdata   = wdata_q;
    case (state_q)
      S_IDLE: begin
        cache_addr = cpu_addr;
        cpu_rdata  = cache_rdata;
        cpu_ready  = cpu_req & ~cpu_we & cache_hit;
      end
      S_MEM_RD: mem_req = 1'b1;
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
      end
      S_FILL: begin
        cache_we    = 1'b1;
        cache_wdata = line_q;
        cpu_ready   = 1'b1;
        cpu_rdata   = line_q;
      end
      S_WR_DONE: begin
        cache_we  = 1'b1;
        cpu_ready = 1'b1;
      end
      S_ERR: begin
        cpu_ready = 1'b1;
        cpu_err   = 1'b1;
      end
      default: ;
    endcase
    // Reset suppresses every strobe, including the combinational hit path.
    if (rst) begin
      cpu_ready = 1'b0;
      cpu_err   = 1'b0;
      cache_we  = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scenario bench for cache_refill_ctrl: per-feature tasks plus a completion scoreboard
// that matches each cpu_ready pulse against the expected response queued at request time.
module tb_cache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_ready, cpu_err;
  logic [31:0] cpu_rdata, cache_addr, cache_wdata;
  logic        cache_we;
  logic [31:0] cache_rdata;
  logic        cache_hit;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] hit_cnt, miss_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        is_load;
    logic [31:0] rdata;
    logic        err;
  } resp_t;
  resp_t exp_q[$];

  cache_refill_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .cache_addr(cache_addr), .cache_wdata(cache_wdata), .cache_we(cache_we),
    .cache_rdata(cache_rdata), .cache_hit(cache_hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  // Completion scoreboard
  always @(negedge clk) begin
    if (rst === 1'b0 && cpu_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_ready: cpu_ready=1 with no outstanding request at %0t", $time);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        if (cpu_err !== e.err || (e.is_load && cpu_rdata !== e.rdata)) begin
          errors++;
          $display("FAIL sb_response: err=%0b rdata=%h, expected err=%0b rdata=%h",
                   cpu_err, cpu_rdata, e.err, e.rdata);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wd;
  endtask

  task automatic test_reset();
    rst = 1'b1; req(1'b0, 32'h100, 32'h0);
    cache_hit = 1'b1; cache_rdata = 32'h5555AAAA; mem_ack = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 2; i++) begin
      tick(); #2;
      checks++;
      if (cpu_ready !== 1'b0 || cache_we !== 1'b0 || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: ready=%b cache_we=%b mem_req=%b, expected 0 0 0",
                 cpu_ready, cache_we, mem_req);
      end
      checks++;
      if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
        errors++;
        $display("FAIL reset_counters: hit=%0d miss=%0d, expected 0 0", hit_cnt, miss_cnt);
      end
    end
    rst = 1'b0; cpu_req = 1'b0; cache_hit = 1'b0;
  endtask

  task automatic test_read_hit();
    tick();
    req(1'b0, 32'h100, 32'h0);
    cache_hit = 1'b1; cache_rdata = 32'hDEADBEEF;
    exp_q.push_back('{1'b1, 32'hDEADBEEF, 1'b0});
    #2;
    checks++;
    if (cpu_ready !== 1'b1 || cpu_rdata !== 32'hDEADBEEF || mem_req !== 1'b0 || cache_addr !== 32'h100) begin
      errors++;
      $display("FAIL hit_same_cycle: ready=%b rdata=%h mem_req=%b caddr=%h, expected 1 deadbeef 0 00000100",
               cpu_ready, cpu_rdata, mem_req, cache_addr);
    end
    tick();
    cpu_req = 1'b0; cache_hit = 1'b0;
    #2;
    checks++;
    if (hit_cnt !== 32'd1 || miss_cnt !== 32'd0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL hit_count: hit=%0d miss=%0d mem_req=%b, expected 1 0 0", hit_cnt, miss_cnt, mem_req);
    end
  endtask

  task automatic test_read_miss();
    tick();
    req(1'b0, 32'h240, 32'h0);
    cache_hit = 1'b0;
    exp_q.push_back('{1'b1, 32'h12345678, 1'b0});
    #2;
    checks++;
    if (cpu_ready !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL miss_cycle0: ready=%b mem_req=%b, expected 0 0", cpu_ready, mem_req);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) begin mem_ack = 1'b1; mem_rdata = 32'h12345678; end
      #2;
      checks++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h240) begin
        errors++;
        $display("FAIL miss_mem_req[%0d]: req=%b we=%b addr=%h, expected 1 0 00000240", i, mem_req, mem_we, mem_addr);
      end
    end
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    #2;
    checks++;
    if (cache_we !== 1'b1 || cache_addr !== 32'h240 || cache_wdata !== 32'h12345678 ||
        cpu_ready !== 1'b1 || cpu_rdata !== 32'h12345678 || mem_req !== 1'b0 || miss_cnt !== 32'd1) begin
      errors++;
      $display("FAIL miss_fill: we=%b caddr=%h cwd=%h ready=%b rdata=%h mem_req=%b miss=%0d, expected 1 240 12345678 1 12345678 0 1",
               cache_we, cache_addr, cache_wdata, cpu_ready, cpu_rdata, mem_req, miss_cnt);
    end
    tick();
    cpu_req = 1'b0;
    #2;
    checks++;
    if (cpu_ready !== 1'b0 || cache_we !== 1'b0 || hit_cnt !== 32'd1) begin
      errors++;
      $display("FAIL miss_return_idle: ready=%b cache_we=%b hit=%0d, expected 0 0 1", cpu_ready, cache_we, hit_cnt);
    end
  endtask

  task automatic test_store();
    tick();
    req(1'b1, 32'h80, 32'hA5A5A5A5);
    cache_hit = 1'b1;
    exp_q.push_back('{1'b0, 32'h0, 1'b0});
    #2;
    checks++;
    if (cpu_ready !== 1'b0) begin
      errors++;
      $display("FAIL store_cycle0: ready=%b, expected 0", cpu_ready);
    end
    tick();
    mem_ack = 1'b1;
    #2;
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h80 || mem_wdata !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL store_mem: req=%b we=%b addr=%h wd=%h, expected 1 1 00000080 a5a5a5a5",
               mem_req, mem_we, mem_addr, mem_wdata);
    end
    tick();
    mem_ack = 1'b0;
    #2;
    checks++;
    if (cache_we !== 1'b1 || cache_addr !== 32'h80 || cache_wdata !== 32'hA5A5A5A5 ||
        cpu_ready !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL store_wr_done: cwe=%b caddr=%h cwd=%h ready=%b mreq=%b mwe=%b, expected 1 80 a5a5a5a5 1 0 0",
               cache_we, cache_addr, cache_wdata, cpu_ready, mem_req, mem_we);
    end
    tick();
    cpu_req = 1'b0; cache_hit = 1'b0;
    #2;
    checks++;
    if (hit_cnt !== 32'd1 || miss_cnt !== 32'd1) begin
      errors++;
      $display("FAIL store_counters: hit=%0d miss=%0d, expected 1 1", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_timeout();
    int req_cycles;
    tick();
    req(1'b0, 32'h300, 32'h0);
    cache_hit = 1'b0; cache_rdata = 32'hFFFF0000;
    exp_q.push_back('{1'b1, 32'h0, 1'b1});
    req_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      tick(); #2;
      if (mem_req === 1'b1) req_cycles++;
    end
    checks++;
    if (req_cycles != 4) begin
      errors++;
      $display("FAIL timeout_req_len: mem_req high %0d cycles, expected 4", req_cycles);
    end
    tick(); #2;
    checks++;
    if (mem_req !== 1'b0 || cpu_ready !== 1'b1 || cpu_err !== 1'b1 || cpu_rdata !== 32'h0 || cache_we !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err: mreq=%b ready=%b err=%b rdata=%h cwe=%b, expected 0 1 1 00000000 0",
               mem_req, cpu_ready, cpu_err, cpu_rdata, cache_we);
    end
    tick();
    cpu_req = 1'b0;
    tick();
    req(1'b0, 32'h304, 32'h0);
    exp_q.push_back('{1'b1, 32'hCAFEF00D, 1'b0});
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) begin mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D; end
      #2;
      checks++;
      if (mem_req !== 1'b1) begin
        errors++;
        $display("FAIL limit_ack_req[%0d]: mem_req=%b, expected 1", i, mem_req);
      end
    end
    tick();
    mem_ack = 1'b0;
    #2;
    checks++;
    if (cpu_ready !== 1'b1 || cpu_err !== 1'b0 || cache_we !== 1'b1 || cache_wdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL limit_ack_fill: ready=%b err=%b cwe=%b cwd=%h, expected 1 0 1 cafef00d",
               cpu_ready, cpu_err, cache_we, cache_wdata);
    end
    tick();
    cpu_req = 1'b0;
    #2;
    checks++;
    if (miss_cnt !== 32'd3) begin
      errors++;
      $display("FAIL timeout_miss_cnt: miss=%0d, expected 3", miss_cnt);
    end
  endtask

  task automatic test_back_to_back();
    tick();
    req(1'b0, 32'h400, 32'h0);
    cache_hit = 1'b0;
    exp_q.push_back('{1'b1, 32'h11110000, 1'b0});
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h11110000;
    tick();
    mem_ack = 1'b0;
    #2;
    checks++;
    if (cpu_ready !== 1'b1 || cpu_rdata !== 32'h11110000) begin
      errors++;
      $display("FAIL b2b_fill: ready=%b rdata=%h, expected 1 11110000", cpu_ready, cpu_rdata);
    end
    tick();
    req(1'b0, 32'h404, 32'h0);
    cache_hit = 1'b1; cache_rdata = 32'h22220000;
    exp_q.push_back('{1'b1, 32'h22220000, 1'b0});
    #2;
    checks++;
    if (cpu_ready !== 1'b1 || cpu_rdata !== 32'h22220000 || cache_addr !== 32'h404) begin
      errors++;
      $display("FAIL b2b_hit: ready=%b rdata=%h caddr=%h, expected 1 22220000 00000404", cpu_ready, cpu_rdata, cache_addr);
    end
    tick();
    cpu_req = 1'b0; cache_hit = 1'b0;
    #2;
    checks++;
    if (hit_cnt !== 32'd2 || miss_cnt !== 32'd4) begin
      errors++;
      $display("FAIL b2b_counters: hit=%0d miss=%0d, expected 2 4", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_reset_mid_miss();
    tick();
    req(1'b0, 32'h500, 32'h0);
    cache_hit = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; cpu_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h77777777;
    #2;
    checks++;
    if (mem_req !== 1'b0 || cpu_ready !== 1'b0 || cache_we !== 1'b0 || miss_cnt !== 32'd0 || hit_cnt !== 32'd0) begin
      errors++;
      $display("FAIL midrst_after_edge: mreq=%b ready=%b cwe=%b miss=%0d hit=%0d, expected 0 0 0 0 0",
               mem_req, cpu_ready, cache_we, miss_cnt, hit_cnt);
    end
    tick();
    mem_ack = 1'b0;
    #2;
    checks++;
    if (mem_req !== 1'b0 || cpu_ready !== 1'b0 || cache_we !== 1'b0) begin
      errors++;
      $display("FAIL midrst_late_ack: mreq=%b ready=%b cwe=%b, expected 0 0 0", mem_req, cpu_ready, cache_we);
    end
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_read_miss();
    test_store();
    test_timeout();
    test_back_to_back();
    test_reset_mid_miss();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
